// File: rtl/icache_ro_2way.sv
// Read-only 2-way set-associative instruction cache with per-set LRU, fence.i flush
// and saturating hit/miss counters. Refills whole 128-bit lines from line memory.

module icache_way #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [INDEX_W-1:0] idx,
    input  logic [TAG_W-1:0]   tag,
    input  logic               wr,
    input  logic [127:0]       wdata,
    output logic               vld,
    output logic               hit,
    output logic [127:0]       line
);
    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [127:0]     data [SETS];

    always_ff @(posedge clk) begin
        if (rst || clr)
            valid <= '0;
        else if (wr)
            valid[idx] <= 1'b1;
    end

    // Tag/data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (wr) begin
            tags[idx] <= tag;
            data[idx] <= wdata;
        end
    end

    assign vld  = valid[idx];
    assign hit  = vld && (tags[idx] == tag);
    assign line = data[idx];
endmodule

module icache_ro_2way #(
    parameter int INDEX_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    input  logic             proc_flush,
    input  logic [29:0]      proc_addr,
    output logic [31:0]      proc_rdata,
    output logic             proc_stall,
    output logic             mem_read,
    output logic [27:0]      mem_addr,
    input  logic [127:0]     mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int TAG_W = 28 - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, ALLOCATE, FLUSH} state_t;

    state_t state, state_nx;

    logic [INDEX_W-1:0]         idx;
    logic [TAG_W-1:0]           tag;
    logic [1:0]                 vld, hit, wr;
    logic [1:0][3:0][31:0]      line;
    logic [SETS-1:0]            lru;
    logic                       flush_seen, clr, hw, victim;
    logic                       hit_inc, miss_inc, lru_wr, lru_val;

    assign idx      = proc_addr[INDEX_W+1:2];
    assign tag      = proc_addr[29:INDEX_W+2];
    assign mem_addr = proc_addr[29:2];
    assign hw       = ~hit[0];

    for (genvar w = 0; w < 2; w++) begin : g_way
        icache_way #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way (
            .clk   (clk),
            .rst   (proc_reset),
            .clr   (clr),
            .idx   (idx),
            .tag   (tag),
            .wr    (wr[w]),
            .wdata (mem_rdata),
            .vld   (vld[w]),
            .hit   (hit[w]),
            .line  (line[w])
        );
    end

    always_comb begin
        state_nx   = state;
        proc_stall = 1'b1;
        proc_rdata = '0;
        mem_read   = 1'b0;
        wr         = '0;
        clr        = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        lru_wr     = 1'b0;
        lru_val    = 1'b0;
        victim     = !vld[0] ? 1'b0 : (!vld[1] ? 1'b1 : lru[idx]);
        unique case (state)
            IDLE: begin
                if (proc_flush) begin
                    state_nx = FLUSH;
                end else if (|hit) begin
                    proc_stall = 1'b0;
                    proc_rdata = line[hw][proc_addr[1:0]];
                    hit_inc    = 1'b1;
                    lru_wr     = 1'b1;
                    lru_val    = ~hw;
                end else begin
                    miss_inc = 1'b1;
                    state_nx = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_nx = IDLE;
                    // A flush anywhere in the refill makes the returning line stale.
                    if (flush_seen || proc_flush) begin
                        clr = 1'b1;
                    end else begin
                        wr[victim] = 1'b1;
                        lru_wr     = 1'b1;
                        lru_val    = ~victim;
                    end
                end
            end
            FLUSH: begin
                clr      = 1'b1;
                state_nx = proc_flush ? FLUSH : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (proc_reset) begin
            state_nx   = IDLE;
            proc_stall = 1'b1;
            proc_rdata = '0;
            mem_read   = 1'b0;
            wr         = '0;
            clr        = 1'b0;
            hit_inc    = 1'b0;
            miss_inc   = 1'b0;
            lru_wr     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state      <= IDLE;
            lru        <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            flush_seen <= 1'b0;
        end else begin
            state      <= state_nx;
            flush_seen <= (state == ALLOCATE) && (state_nx == ALLOCATE) && (flush_seen || proc_flush);
            if (lru_wr)
                lru[idx] <= lru_val;
            if (hit_inc && (hit_cnt != '1))
                hit_cnt <= hit_cnt + CNT_W'(1);
            if (miss_inc && (miss_cnt != '1))
                miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_icache_ro_2way.sv
// Randomized self-checking bench for icache_ro_2way against a recency-list cache model.
module tb_icache_ro_2way;
    localparam int INDEX_W = 3;
    localparam int CNT_W   = 4;
    localparam int TAG_W   = 25;
    localparam int SETS    = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             proc_reset, proc_flush, proc_stall, mem_read, mem_ready;
    logic [29:0]      proc_addr;
    logic [31:0]      proc_rdata;
    logic [27:0]      mem_addr;
    logic [127:0]     mem_rdata;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // Per set: resident tags in recency order (slot 0 = most recent), and count.
    logic [TAG_W-1:0] mt [SETS][2];
    int               mc [SETS];
    int               mh, mm;

    always #5 clk = ~clk;

    icache_ro_2way #(.INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_flush (proc_flush),
        .proc_addr  (proc_addr),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [27:0] la, input int k);
        return (32'(la) * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA6B) ^ 32'hC0DE0000;
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = word_of(la, k);
        return l;
    endfunction

    function automatic bit present(input int s, input logic [TAG_W-1:0] t);
        return (mc[s] > 0 && mt[s][0] == t) || (mc[s] > 1 && mt[s][1] == t);
    endfunction

    task automatic touch(input int s, input logic [TAG_W-1:0] t);
        if (mc[s] == 2 && mt[s][1] == t) begin
            mt[s][1] = mt[s][0];
            mt[s][0] = t;
        end
    endtask

    task automatic insert(input int s, input logic [TAG_W-1:0] t);
        mt[s][1] = mt[s][0];
        mt[s][0] = t;
        mc[s]    = (mc[s] == 0) ? 1 : 2;
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) mc[s] = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        proc_reset = 1'b1;
        cyc();
        #1;
        chk("rst_stall", proc_stall, 1);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_rdata", proc_rdata, 0);
        cyc();
        proc_reset = 1'b0;
        model_clear();
        mh = 0;
        mm = 0;
    endtask

    // One fetch from IDLE until data returns; fl_at = refill cycle to pulse flush (-1: none).
    task automatic fetch(input logic [29:0] a, input int fl_at);
        int               s = int'(a[4:2]);
        logic [TAG_W-1:0] t = a[29:5];
        int               lat;
        int               fa = fl_at;
        bit               fl;
        bit               done = 1'b0;
        proc_addr = a;
        for (int tries = 0; tries < 3 && !done; tries++) begin
            #1;
            chk("hit_cnt", 32'(hit_cnt), mh);
            chk("miss_cnt", 32'(miss_cnt), mm);
            chk("idle_mem_read", mem_read, 0);
            if (present(s, t)) begin
                chk("hit_stall", proc_stall, 0);
                chk("hit_rdata", proc_rdata, word_of(a[29:2], int'(a[1:0])));
                mh = (mh < MAXC) ? mh + 1 : MAXC;
                touch(s, t);
                done = 1'b1;
                cyc();
            end else begin
                chk("miss_stall", proc_stall, 1);
                chk("miss_rdata", proc_rdata, 0);
                mm = (mm < MAXC) ? mm + 1 : MAXC;
                cyc();
                lat = $urandom_range(0, 3);
                fl  = 1'b0;
                for (int i = 0; i <= lat; i++) begin
                    proc_flush = (i == fa);
                    mem_ready  = (i == lat);
                    mem_rdata  = line_of(a[29:2]);
                    #1;
                    chk("alloc_mem_read", mem_read, 1);
                    chk("alloc_mem_addr", 32'(mem_addr), 32'(a[29:2]));
                    chk("alloc_stall", proc_stall, 1);
                    fl |= proc_flush;
                    cyc();
                end
                proc_flush = 1'b0;
                mem_ready  = 1'b0;
                mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
                if (fl) model_clear();
                else insert(s, t);
                fa = -1;
            end
        end
        chk("fetch_done", done, 1);
    endtask

    task automatic flush_idle();
        proc_flush = 1'b1;
        #1;
        chk("flush_stall", proc_stall, 1);
        chk("flush_mem_read", mem_read, 0);
        cyc();
        proc_flush = 1'b0;
        #1;
        chk("flush_state_stall", proc_stall, 1);
        cyc();
        model_clear();
    endtask

    initial begin
        proc_reset = 1'b1;
        proc_flush = 1'b0;
        proc_addr  = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        do_reset();

        // Cold miss, then the rest of the same line hits.
        fetch(30'h4, -1);
        for (int w = 5; w < 8; w++) fetch(30'(w), -1);

        // Set 0 conflict: A, B, A, B, C evicts B, A hits, B misses.
        fetch(30'h00, -1);
        fetch(30'h20, -1);
        fetch(30'h00, -1);
        fetch(30'h20, -1);
        fetch(30'h00, -1);
        fetch(30'h40, -1);
        fetch(30'h00, -1);
        fetch(30'h20, -1);

        flush_idle();
        fetch(30'h04, -1);
        fetch(30'h00, -1);

        // Flush during refill drops the line; re-lookup misses again.
        fetch(30'h100, 0);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 21; i++) fetch(30'h8, -1);
        chk("hit_sat", 32'(hit_cnt), 15);
        chk("miss_after_sat", 32'(miss_cnt), 1);

        // Reset mid-refill, with a stray mem_ready while in reset.
        flush_idle();
        proc_addr = 30'h8;
        #1;
        cyc();
        chk("pre_rst_mem_read", mem_read, 1);
        proc_reset = 1'b1;
        #1;
        chk("midrst_mem_read", mem_read, 0);
        chk("midrst_stall", proc_stall, 1);
        cyc();
        mem_ready = 1'b1;
        mem_rdata = line_of(28'h2);
        #1;
        chk("midrst_stray_read", mem_read, 0);
        cyc();
        mem_ready  = 1'b0;
        proc_reset = 1'b0;
        model_clear();
        mh = 0;
        mm = 0;
        fetch(30'h8, -1);

        // Randomized traffic over a small tag pool to force evictions.
        do_reset();
        for (int n = 0; n < 250; n++) begin
            logic [29:0] a;
            a = (30'($urandom_range(0, 3)) << 5) | (30'($urandom_range(0, 7)) << 2) |
                30'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) flush_idle();
            fetch(a, ($urandom_range(0, 9) == 0) ? 0 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
